// File: rtl/cg_vector_store.sv
// Double-buffered chunked vector store: one bank fills from the CG datapath while the other
// streams the previous iteration's vector back out; a swap exchanges them between iterations.
module cg_vector_store #(
    parameter int unsigned number_of_equations_per_cluster = 10,
    parameter int unsigned no_of_units                     = 8,
    parameter int unsigned element_width                   = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wr_we,
    input  logic [element_width*no_of_units-1:0]   wr_data,
    output logic                                   wr_done,
    output logic                                   wr_overflow,
    input  logic                                   rd_start,
    input  logic                                   rd_ready,
    output logic                                   rd_valid,
    output logic [element_width*no_of_units-1:0]   rd_data,
    output logic [31:0]                            rd_address,
    output logic                                   rd_last,
    output logic                                   rd_busy,
    input  logic                                   swap,
    output logic                                   swap_pending,
    output logic                                   bank_sel
);
    localparam int unsigned N      = number_of_equations_per_cluster;
    localparam int unsigned U      = no_of_units;
    localparam int unsigned EW     = element_width;
    localparam int unsigned DW     = EW * U;
    localparam int unsigned CHUNKS = (N + U - 1) / U;
    localparam int unsigned CW     = $clog2(CHUNKS + 1);
    localparam int unsigned DEPTH  = 2 * CHUNKS;
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } rd_state_t;

    rd_state_t     state;
    logic [CW-1:0] wc;
    logic [CW-1:0] rc;
    logic [DW-1:0] mem [DEPTH];

    logic          wr_full_c;
    logic          wr_accept_c;
    logic          swap_apply_c;
    logic          rd_bank_c;
    logic          rd_load_c;
    logic          rd_is_last_c;
    logic [CW-1:0] rd_idx_c;
    logic [AW-1:0] wr_addr_c;
    logic [AW-1:0] rd_addr_c;
    logic [DW-1:0] wr_padded_c;
    logic [DW-1:0] rd_mem_c;

    // Swaps only land when no stream is running and no write is in flight,
    // so the read bank is frozen for the whole lifetime of a stream.
    always_comb begin
        wr_full_c    = (wc == CW'(CHUNKS));
        wr_accept_c  = wr_we && !wr_full_c;
        swap_apply_c = (swap || swap_pending) && (state == IDLE) && !wr_we;
        rd_bank_c    = bank_sel ^ swap_apply_c;
        rd_idx_c     = (state == IDLE) ? '0 : rc;
        rd_is_last_c = (rd_idx_c == CW'(CHUNKS - 1));
        rd_load_c    = 1'b0;
        case (state)
            IDLE:    rd_load_c = rd_start;
            STREAM:  rd_load_c = !rd_valid || rd_ready;
            default: rd_load_c = 1'b0;
        endcase
        wr_addr_c = bank_sel  ? AW'(wc) : AW'(CHUNKS) + AW'(wc);
        rd_addr_c = rd_bank_c ? AW'(CHUNKS) + AW'(rd_idx_c) : AW'(rd_idx_c);
        rd_mem_c  = mem[rd_addr_c];
    end

    // Lanes past the end of the vector are stored as zero.
    always_comb begin
        wr_padded_c = '0;
        for (int k = 0; k < int'(U); k++) begin
            if (32'(wc) * U + 32'(k) < N)
                wr_padded_c[EW*k +: EW] = wr_data[EW*k +: EW];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept_c)
            mem[wr_addr_c] <= wr_padded_c;
    end

    // Write counter, bank selection and swap bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wc           <= '0;
            wr_done      <= 1'b0;
            wr_overflow  <= 1'b0;
            swap_pending <= 1'b0;
            bank_sel     <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            if (swap_apply_c) begin
                bank_sel     <= ~bank_sel;
                wc           <= '0;
                wr_overflow  <= 1'b0;
                swap_pending <= 1'b0;
            end else begin
                if (swap)
                    swap_pending <= 1'b1;
                if (wr_accept_c) begin
                    wc      <= wc + CW'(1);
                    wr_done <= (wc == CW'(CHUNKS - 1));
                end else if (wr_we) begin
                    wr_overflow <= 1'b1;
                end
            end
        end
    end

    // Read stream FSM with a single output register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rc         <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_address <= '0;
            rd_last    <= 1'b0;
            rd_busy    <= 1'b0;
        end else begin
            if (rd_load_c) begin
                rd_valid   <= 1'b1;
                rd_busy    <= 1'b1;
                rd_data    <= rd_mem_c;
                rd_address <= 32'(rd_idx_c);
                rd_last    <= rd_is_last_c;
                rc         <= rd_idx_c + CW'(1);
                state      <= rd_is_last_c ? DRAIN : STREAM;
            end else if (state == DRAIN && rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
                rd_busy  <= 1'b0;
                rd_last  <= 1'b0;
                state    <= IDLE;
            end else if (state != IDLE && state != STREAM && state != DRAIN) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_cg_vector_store.sv
// Randomised bench for cg_vector_store: a vector-level reference model feeds an expected-beat
// queue, and a negedge monitor checks every presented chunk and status flag against it.
module tb_cg_vector_store;
    localparam int unsigned N  = 10;
    localparam int unsigned U  = 8;
    localparam int unsigned EW = 32;
    localparam int unsigned DW = EW * U;
    localparam int unsigned CH = (N + U - 1) / U;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_we = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_done;
    logic          wr_overflow;
    logic          rd_start = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [31:0]   rd_address;
    logic          rd_last;
    logic          rd_busy;
    logic          swap = 1'b0;
    logic          swap_pending;
    logic          bank_sel;

    cg_vector_store #(
        .number_of_equations_per_cluster(N),
        .no_of_units(U),
        .element_width(EW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_we(wr_we),
        .wr_data(wr_data),
        .wr_done(wr_done),
        .wr_overflow(wr_overflow),
        .rd_start(rd_start),
        .rd_ready(rd_ready),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_address(rd_address),
        .rd_last(rd_last),
        .rd_busy(rd_busy),
        .swap(swap),
        .swap_pending(swap_pending),
        .bank_sel(bank_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        bit            known;
        logic [31:0]   addr;
        bit            last;
    } beat_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;

    // Reference model: whole vectors per bank, element-indexed.
    logic [EW-1:0] m_vec   [2][CH*U];
    bit            m_known [2][CH];
    bit            m_bank, m_ovf, m_pend, m_busy, m_done, m_idle;
    int            m_wc, m_acc, m_wb, m_idx;
    beat_t         m_beat;
    beat_t         exp_q[$];

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_bank = 1'b0; m_ovf = 1'b0; m_pend = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_wc = 0; m_acc = 0;
            exp_q.delete();
        end else begin
            m_idle = !m_busy;
            m_done = 1'b0;
            if (m_busy && rd_ready) begin
                m_acc++;
                if (m_acc == int'(CH)) m_busy = 1'b0;
            end
            if ((swap || m_pend) && m_idle && !wr_we) begin
                m_bank = !m_bank; m_wc = 0; m_ovf = 1'b0; m_pend = 1'b0;
            end else if (swap) begin
                m_pend = 1'b1;
            end
            if (wr_we) begin
                if (m_wc < int'(CH)) begin
                    m_wb = m_bank ? 0 : 1;
                    for (int k = 0; k < int'(U); k++) begin
                        m_idx = m_wc * int'(U) + k;
                        m_vec[m_wb][m_idx] = (m_idx < int'(N)) ? wr_data[EW*k +: EW] : '0;
                    end
                    m_known[m_wb][m_wc] = 1'b1;
                    m_done = (m_wc == int'(CH) - 1);
                    m_wc++;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (rd_start && m_idle) begin
                m_busy = 1'b1;
                m_acc  = 0;
                m_wb   = m_bank ? 1 : 0;
                for (int c = 0; c < int'(CH); c++) begin
                    m_beat.data = '0;
                    for (int k = 0; k < int'(U); k++)
                        m_beat.data[EW*k +: EW] = m_vec[m_wb][c*int'(U) + k];
                    m_beat.known = m_known[m_wb][c];
                    m_beat.addr  = 32'(c);
                    m_beat.last  = (c == int'(CH) - 1);
                    exp_q.push_back(m_beat);
                end
            end
        end
    end

    // Monitor: status flags every cycle, presented chunk against the queue head.
    always @(negedge clk) begin
        if (reset) begin
            chk_bit("rd_busy", rd_busy, m_busy);
            chk_bit("rd_valid", rd_valid, m_busy);
            chk_bit("bank_sel", bank_sel, m_bank);
            chk_bit("swap_pending", swap_pending, m_pend);
            chk_bit("wr_overflow", wr_overflow, m_ovf);
            chk_bit("wr_done", wr_done, m_done);
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    chk_int("unexpected beat queue size", 0, 1);
                end else begin
                    if (exp_q[0].known) chk_vec("rd_data", rd_data, exp_q[0].data);
                    chk_vec("rd_address", DW'(rd_address), DW'(exp_q[0].addr));
                    chk_bit("rd_last", rd_last, exp_q[0].last);
                    if (rd_ready) begin
                        void'(exp_q.pop_front());
                        n_acc++;
                    end
                end
            end else begin
                chk_bit("rd_last idle", rd_last, 1'b0);
            end
        end
    end

    task automatic cyc(input bit we, input logic [DW-1:0] d, input bit st, input bit rdy, input bit sw);
        wr_we = we; wr_data = d; rd_start = st; rd_ready = rdy; swap = sw;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (rd_busy && n < max_cyc) begin
            cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
            n++;
        end
        chk_bit("wait_idle rd_busy", rd_busy, 1'b0);
    endtask

    function automatic logic [DW-1:0] rand_chunk();
        logic [DW-1:0] v;
        for (int k = 0; k < int'(U); k++) v[EW*k +: EW] = $urandom;
        return v;
    endfunction

    logic [DW-1:0] ones, chunk1_exp;
    bit            b_before;
    int            a0;

    initial begin
        ones       = {U{32'h3F80_0000}};
        chunk1_exp = {{(U-2){32'h0}}, {2{32'h3F80_0000}}};

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_bit("reset rd_valid", rd_valid, 1'b0);
        chk_vec("reset rd_data", rd_data, '0);
        chk_vec("reset rd_address", DW'(rd_address), '0);
        chk_bit("reset rd_last", rd_last, 1'b0);
        chk_bit("reset rd_busy", rd_busy, 1'b0);
        chk_bit("reset bank_sel", bank_sel, 1'b0);
        chk_bit("reset swap_pending", swap_pending, 1'b0);
        chk_bit("reset wr_overflow", wr_overflow, 1'b0);
        chk_bit("reset wr_done", wr_done, 1'b0);

        // First read: valid the cycle after rd_start, chunk 0.
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk_bit("start rd_valid", rd_valid, 1'b1);
        chk_vec("start rd_address", DW'(rd_address), '0);
        wait_idle(20);

        // Fill with 1.0f, overflow once, swap and read back with padding.
        cyc(1'b1, ones, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, ones, 1'b0, 1'b1, 1'b0);
        chk_bit("fill wr_done", wr_done, 1'b1);
        cyc(1'b1, {U{32'hDEAD_BEEF}}, 1'b0, 1'b1, 1'b0);
        chk_bit("overflow set", wr_overflow, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk_bit("swap bank_sel", bank_sel, 1'b1);
        chk_bit("swap clears overflow", wr_overflow, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk_vec("fill chunk0", rd_data, ones);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk_vec("fill chunk1 padded", rd_data, chunk1_exp);
        chk_vec("fill chunk1 address", DW'(rd_address), DW'(32'd1));
        chk_bit("fill chunk1 last", rd_last, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk_bit("fill done rd_busy", rd_busy, 1'b0);
        chk_bit("fill done rd_valid", rd_valid, 1'b0);

        // Backpressure: three stalled cycles mid-stream.
        cyc(1'b1, rand_chunk(), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, rand_chunk(), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        a0 = n_acc;
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        wait_idle(20);
        chk_int("backpressure accepted", n_acc - a0, int'(CH));

        // Swap requested mid-stream is deferred until the stream ends.
        cyc(1'b1, rand_chunk(), 1'b0, 1'b1, 1'b0);
        cyc(1'b1, rand_chunk(), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
        b_before = m_bank;
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk_bit("deferred pending", swap_pending, 1'b1);
        chk_bit("deferred bank held", bank_sel, b_before);
        wait_idle(20);
        chk_bit("deferred bank still held", bank_sel, b_before);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk_bit("deferred bank toggled", bank_sel, !b_before);
        chk_bit("deferred pending clear", swap_pending, 1'b0);

        // Asynchronous reset in the middle of a stream.
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk_bit("async rd_valid", rd_valid, 1'b0);
        chk_bit("async rd_busy", rd_busy, 1'b0);
        chk_bit("async bank_sel", bank_sel, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk_bit("post-reset rd_valid", rd_valid, 1'b1);
        chk_vec("post-reset rd_address", DW'(rd_address), '0);
        wait_idle(20);

        // Random traffic on every input.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 30, rand_chunk(), $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 5);
        end
        wait_idle(50);
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk_int("queue drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
